// File: rtl/solver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : solver_pkg
// Purpose  : Shared types and fixed-point helpers for the stream_multi_solver
//            escape-time frame solver.
// Contents : FOUR_FIX (4.0 at the default fraction width), four_fix(),
//            fx_mul_shr(), lane state enum, frame FSM enum.
// Revision : 1.0 - initial release
// ============================================================================
package solver_pkg;

  localparam int DEF_FRAC_W = 20;

  // 4.0 in fixed point at the default fraction width
  localparam logic signed [63:0] FOUR_FIX = 64'sd4 <<< DEF_FRAC_W;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_ITER = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_e;

  typedef enum logic [1:0] {
    FRM_IDLE  = 2'd0,
    FRM_RUN   = 2'd1,
    FRM_DRAIN = 2'd2,
    FRM_FLUSH = 2'd3
  } frame_state_e;

  // 4.0 at an arbitrary fraction width
  function automatic logic signed [63:0] four_fix(input int frac_w);
    return 64'sd4 <<< frac_w;
  endfunction

  // Full-precision product of two sign-extended operands followed by an
  // arithmetic right shift. Operands are at most 32 bits wide, so the
  // 64-bit product is exact.
  function automatic logic signed [63:0] fx_mul_shr(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 sh
  );
    logic signed [63:0] p;
    p = a * b;
    return p >>> sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/escape_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : escape_iter_core
// Purpose  : One Mandelbrot iteration lane. Captures c and the pixel tag on
//            issue, iterates z <- z^2 + c one step per cycle, then holds the
//            result until the output arbiter grants it.
// Ports    : clk, rst         clock, asynchronous active-high reset
//            i_clear          drop any work in flight (frame abort)
//            i_issue          start a pixel (only sampled while idle)
//            i_c_re, i_c_im   pixel coordinate c
//            i_max_iter       iteration limit, already forced to >= 1
//            i_x, i_y         pixel tag carried with the result
//            i_grant          result consumed by the output register
//            o_idle, o_done   lane state flags
//            o_iter, o_escaped, o_x, o_y  held result
// Revision : 1.0 - initial release
// ============================================================================
module escape_iter_core
  import solver_pkg::*;
#(
  parameter int DATA_W = 27,
  parameter int FRAC_W = 20,
  parameter int ITER_W = 8,
  parameter int XW     = 7,
  parameter int YW     = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_issue,
  input  logic signed [DATA_W-1:0] i_c_re,
  input  logic signed [DATA_W-1:0] i_c_im,
  input  logic [ITER_W-1:0]        i_max_iter,
  input  logic [XW-1:0]            i_x,
  input  logic [YW-1:0]            i_y,
  input  logic                     i_grant,
  output logic                     o_idle,
  output logic                     o_done,
  output logic [ITER_W-1:0]        o_iter,
  output logic                     o_escaped,
  output logic [XW-1:0]            o_x,
  output logic [YW-1:0]            o_y
);

  lane_state_e              r_state;
  logic signed [DATA_W-1:0] r_zr;
  logic signed [DATA_W-1:0] r_zi;
  logic signed [DATA_W-1:0] r_cre;
  logic signed [DATA_W-1:0] r_cim;
  logic [ITER_W-1:0]        r_n;
  logic                     r_esc;
  logic [XW-1:0]            r_x;
  logic [YW-1:0]            r_y;

  logic signed [DATA_W-1:0] w_zr2;
  logic signed [DATA_W-1:0] w_zi2;
  logic signed [DATA_W-1:0] w_zri;
  logic signed [DATA_W-1:0] w_zr_nx;
  logic signed [DATA_W-1:0] w_zi_nx;
  logic signed [DATA_W:0]   w_mag;
  logic signed [63:0]       w_four;
  logic                     w_escape;

  always_comb begin
    w_zr2    = DATA_W'(fx_mul_shr(64'(r_zr), 64'(r_zr), FRAC_W));
    w_zi2    = DATA_W'(fx_mul_shr(64'(r_zi), 64'(r_zi), FRAC_W));
    // shifting one bit less folds in the factor of two of 2*zr*zi
    w_zri    = DATA_W'(fx_mul_shr(64'(r_zr), 64'(r_zi), FRAC_W - 1));
    // |z|^2 needs one extra bit so the sum cannot wrap before the compare
    w_mag    = {w_zr2[DATA_W-1], w_zr2} + {w_zi2[DATA_W-1], w_zi2};
    w_four   = four_fix(FRAC_W);
    w_escape = (64'(w_mag) >= w_four);
    w_zr_nx  = w_zr2 - w_zi2 + r_cre;
    w_zi_nx  = w_zri + r_cim;
  end

  // z0 = 0 can never escape and the limit is at least 1, so the first step
  // (z1 = c, n = 1) is taken in the issue cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LANE_IDLE;
      r_zr    <= '0;
      r_zi    <= '0;
      r_cre   <= '0;
      r_cim   <= '0;
      r_n     <= '0;
      r_esc   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (i_clear) begin
      r_state <= LANE_IDLE;
    end else begin
      case (r_state)
        LANE_IDLE: begin
          if (i_issue) begin
            r_state <= LANE_ITER;
            r_cre   <= i_c_re;
            r_cim   <= i_c_im;
            r_zr    <= i_c_re;
            r_zi    <= i_c_im;
            r_n     <= ITER_W'(1);
            r_esc   <= 1'b0;
            r_x     <= i_x;
            r_y     <= i_y;
          end
        end
        LANE_ITER: begin
          // reaching the limit takes precedence: escaped means n < max_iter
          if (r_n == i_max_iter) begin
            r_state <= LANE_DONE;
            r_esc   <= 1'b0;
          end else if (w_escape) begin
            r_state <= LANE_DONE;
            r_esc   <= 1'b1;
          end else begin
            r_zr <= w_zr_nx;
            r_zi <= w_zi_nx;
            r_n  <= r_n + ITER_W'(1);
          end
        end
        LANE_DONE: begin
          if (i_grant) begin
            r_state <= LANE_IDLE;
          end
        end
        default: r_state <= LANE_IDLE;
      endcase
    end
  end

  assign o_idle    = (r_state == LANE_IDLE);
  assign o_done    = (r_state == LANE_DONE);
  assign o_iter    = r_n;
  assign o_escaped = r_esc;
  assign o_x       = r_x;
  assign o_y       = r_y;

endmodule
`default_nettype wire

// File: rtl/stream_multi_solver.sv
`default_nettype none
// ============================================================================
// Module   : stream_multi_solver
// Purpose  : Multi-lane escape-time frame solver. Raster-scans a WIDTH x
//            HEIGHT grid, hands each pixel to the lowest-index idle lane and
//            streams (x, y, iter, escaped) out over valid/ready.
// Ports    : clk, rst                  clock, asynchronous active-high reset
//            i_start, i_abort          frame control
//            i_min_x, i_min_y          c of pixel (0,0)
//            i_dx, i_dy                per-pixel / per-row step
//            i_max_iter                iteration limit (0 behaves as 1)
//            o_busy, o_done            frame status, done is a 1-cycle pulse
//            o_out_valid, i_out_ready  result stream handshake
//            o_out_x, o_out_y, o_out_iter, o_out_escaped  result payload
// Revision : 1.0 - initial release
// ============================================================================
module stream_multi_solver
  import solver_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int WIDTH     = 99,
  parameter  int HEIGHT    = 66,
  parameter  int DATA_W    = 27,
  parameter  int FRAC_W    = 20,
  parameter  int ITER_W    = 8,
  localparam int XW        = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic signed [DATA_W-1:0] i_min_x,
  input  logic signed [DATA_W-1:0] i_min_y,
  input  logic signed [DATA_W-1:0] i_dx,
  input  logic signed [DATA_W-1:0] i_dy,
  input  logic [ITER_W-1:0]        i_max_iter,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [XW-1:0]            o_out_x,
  output logic [YW-1:0]            o_out_y,
  output logic [ITER_W-1:0]        o_out_iter,
  output logic                     o_out_escaped
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  frame_state_e             r_state;
  logic                     r_busy;
  logic                     r_done;
  logic signed [DATA_W-1:0] r_min_x;
  logic signed [DATA_W-1:0] r_dx;
  logic signed [DATA_W-1:0] r_dy;
  logic [ITER_W-1:0]        r_max_iter;
  logic [XW-1:0]            r_x;
  logic [YW-1:0]            r_y;
  logic signed [DATA_W-1:0] r_cre;
  logic signed [DATA_W-1:0] r_cim;
  logic [LW-1:0]            r_rr;
  logic                     r_out_valid;
  logic [XW-1:0]            r_out_x;
  logic [YW-1:0]            r_out_y;
  logic [ITER_W-1:0]        r_out_iter;
  logic                     r_out_esc;

  logic [NUM_LANES-1:0] w_idle;
  logic [NUM_LANES-1:0] w_ldone;
  logic [NUM_LANES-1:0] w_issue;
  logic [NUM_LANES-1:0] w_grant;
  logic [ITER_W-1:0]    w_l_iter [NUM_LANES];
  logic                 w_l_esc  [NUM_LANES];
  logic [XW-1:0]        w_l_x    [NUM_LANES];
  logic [YW-1:0]        w_l_y    [NUM_LANES];

  logic          w_do_issue;
  logic          w_abort_take;
  logic          w_clear;
  logic          w_gnt_any;
  logic [LW-1:0] w_gnt_idx;
  logic          w_load;
  logic          w_finish;

  // --------------------------------------------------------------------------
  // Lanes
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    escape_iter_core #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ITER_W (ITER_W),
      .XW     (XW),
      .YW     (YW)
    ) u_core (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_issue    (w_issue[gi]),
      .i_c_re     (r_cre),
      .i_c_im     (r_cim),
      .i_max_iter (r_max_iter),
      .i_x        (r_x),
      .i_y        (r_y),
      .i_grant    (w_grant[gi]),
      .o_idle     (w_idle[gi]),
      .o_done     (w_ldone[gi]),
      .o_iter     (w_l_iter[gi]),
      .o_escaped  (w_l_esc[gi]),
      .o_x        (w_l_x[gi]),
      .o_y        (w_l_y[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Dispatch: one pixel per cycle to the lowest-index idle lane
  // --------------------------------------------------------------------------
  always_comb begin
    w_issue = '0;
    if (r_state == FRM_RUN) begin
      // descending scan so the lowest idle index is the one left standing
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (w_idle[i]) begin
          w_issue    = '0;
          w_issue[i] = 1'b1;
        end
      end
    end
  end

  assign w_do_issue   = |w_issue;
  assign w_abort_take = i_abort && ((r_state == FRM_RUN) || (r_state == FRM_DRAIN));
  assign w_clear      = w_abort_take || (r_state == FRM_FLUSH);

  // --------------------------------------------------------------------------
  // Round-robin arbiter over finished lanes, starting at r_rr
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      automatic int idx = int'(r_rr) + k;
      if (idx >= NUM_LANES) begin
        idx = idx - NUM_LANES;
      end
      if (w_ldone[idx] && !w_gnt_any) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = LW'(idx);
      end
    end
  end

  assign w_load = w_gnt_any && (!r_out_valid || i_out_ready) && !w_clear;

  always_comb begin
    w_grant = '0;
    if (w_load) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  // Frame is complete once every lane is empty and the last result leaves
  // the output register in this cycle (or it is already empty).
  assign w_finish = (&w_idle) && (!r_out_valid || i_out_ready);

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_iter  <= '0;
      r_out_esc   <= 1'b0;
      r_rr        <= '0;
    end else if (w_clear) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_x     <= w_l_x[w_gnt_idx];
      r_out_y     <= w_l_y[w_gnt_idx];
      r_out_iter  <= w_l_iter[w_gnt_idx];
      r_out_esc   <= w_l_esc[w_gnt_idx];
      r_rr        <= (w_gnt_idx == LW'(NUM_LANES - 1)) ? '0 : w_gnt_idx + LW'(1);
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM and pixel counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FRM_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_min_x    <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_max_iter <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_cre      <= '0;
      r_cim      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        FRM_IDLE: begin
          if (i_start) begin
            r_state    <= FRM_RUN;
            r_busy     <= 1'b1;
            r_min_x    <= i_min_x;
            r_dx       <= i_dx;
            r_dy       <= i_dy;
            r_max_iter <= (i_max_iter == '0) ? ITER_W'(1) : i_max_iter;
            r_x        <= '0;
            r_y        <= '0;
            r_cre      <= i_min_x;
            r_cim      <= i_min_y;
          end
        end
        FRM_RUN: begin
          if (i_abort) begin
            r_state <= FRM_FLUSH;
          end else if (w_do_issue) begin
            if (r_x == XW'(WIDTH - 1)) begin
              r_x   <= '0;
              r_cre <= r_min_x;
              if (r_y == YW'(HEIGHT - 1)) begin
                r_state <= FRM_DRAIN;
              end else begin
                r_y   <= r_y + YW'(1);
                r_cim <= r_cim + r_dy;
              end
            end else begin
              r_x   <= r_x + XW'(1);
              r_cre <= r_cre + r_dx;
            end
          end
        end
        FRM_DRAIN: begin
          if (i_abort) begin
            r_state <= FRM_FLUSH;
          end else if (w_finish) begin
            r_state <= FRM_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FRM_FLUSH: begin
          r_state <= FRM_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= FRM_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_out_valid   = r_out_valid;
  assign o_out_x       = r_out_x;
  assign o_out_y       = r_out_y;
  assign o_out_iter    = r_out_iter;
  assign o_out_escaped = r_out_esc;

endmodule
`default_nettype wire

// File: doc/stream_multi_solver.md
# stream_multi_solver

Parametrised multi-lane escape-time (Mandelbrot) frame solver, successor to `multi_solver`. It raster-scans a WIDTH×HEIGHT pixel grid, dispatches each pixel to the lowest-index free iteration lane, and emits results on a valid/ready stream tagged with (x, y). This replaces the per-solver result memory and `rd_solver_id`/`rd_addr` read port. Adds runtime iteration limit, abort, and output backpressure; sits between the frame-parameter registers and the colour-mapping/framebuffer writer.

## Interface
- NUM_LANES, 4, parallel iteration lanes (1..32)
- WIDTH, 99, pixels per row
- HEIGHT, 66, rows per frame
- DATA_W, 27, signed fixed-point width; must be ≥ FRAC_W+5
- FRAC_W, 20, fractional bits
- ITER_W, 8, iteration counter width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin frame; honoured only when busy=0
- abort  in  1  cancel frame; ignored when idle
- min_x, min_y  in  DATA_W  signed, coordinate of pixel (0,0)
- dx, dy  in  DATA_W  signed, per-pixel / per-row step
- max_iter  in  ITER_W  iteration limit, latched at start; 0 treated as 1
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame completed normally
- out_valid  in/out: out  1  result available
- out_ready  in  1  consumer accepts
- out_x  out  clog2(WIDTH); out_y  out  clog2(HEIGHT)
- out_iter  out  ITER_W  iterations completed
- out_escaped  out  1  1 = escaped, 0 = hit max_iter

## Operation
- FSM: IDLE → RUN (start & !busy; latches min_x/min_y/dx/dy/max_iter) → DRAIN (all pixels dispatched) → IDLE (all lanes idle & output reg empty; pulse done). abort in RUN/DRAIN → FLUSH (one cycle: lanes and output reg cleared) → IDLE, no done.
- Dispatcher: pixel counter x (inner), y (outer); c_re accumulates +dx per x, reloads min_x at row wrap; c_im = min_y + y·dy by accumulation. At most one issue per cycle, to lowest-index idle lane.
- Lane (escape_iter_core): z0 = 0. Each cycle: zr2 = (zr·zr)>>>FRAC_W, zi2 likewise, zri = (zr·zi)>>>(FRAC_W−1); escape test zr2+zi2 ≥ 4.0 (4<<FRAC_W, evaluated at DATA_W+1 bits) on current z before update; else z ← (zr2−zi2+c_re, zri+c_im), n++. Stop on escape (escaped=1, iter=n) or n == max_iter (escaped=0, iter=max_iter). Products full 2·DATA_W, shifted, truncated to DATA_W.
- Lane holds result (state DONE) until granted to output; then IDLE.
- Output: one-entry register. Loads from round-robin arbiter among DONE lanes when !out_valid | out_ready; pointer advances past granted lane. Payload stable while out_valid & !out_ready.
- Start while busy, or abort while idle: no effect. Start and abort same cycle while idle: start wins.

## Timing
- Reset values: busy, done, out_valid, out_x, out_y, out_iter, out_escaped = 0; all lanes IDLE.
- busy rises cycle after start accepted; falls in the done cycle (or the FLUSH-exit cycle).
- Lane latency: issued at cycle t → lane DONE at t+1+iter (escape check occupies one cycle per tested z).
- Output: with out_ready=1, out_valid in cycle after lane DONE; first result ≥ iter+3 cycles after start.
- done: the cycle after the handshake of the last result.
- Abort: busy=0, out_valid=0 within 2 cycles; in-flight results discarded.
- Async reset mid-frame: outputs 0 immediately, no further results.

## Structure
- Package solver_pkg: FOUR_FIX constant (4<<FRAC_W), fixed-point mul/shift function, lane state enum (IDLE/ITER/DONE), frame FSM enum.
- Sub-module escape_iter_core (one lane: c capture, iterate, result hold). Top holds dispatcher, arbiter, output register, FSM.

## Test plan
- WIDTH=HEIGHT=1, min=(0,0), max_iter=10 → one result x=0,y=0,iter=10,escaped=0; done once the cycle after the handshake.
- WIDTH=HEIGHT=1, min_x=2<<20, min_y=0 → iter=1, escaped=1 after 2 lane cycles.
- 99×66, min_x=−2<<20, min_y=−1<<20, dx=dy=31776, max_iter=255, NUM_LANES=4, out_ready=1 → exactly 6534 results, each (x,y) once, iter/escaped match golden C model, single done.
- Same frame, out_ready randomly 30% low plus a 200-cycle hold low → identical result set, payload stable while stalled, never more than NUM_LANES pixels in flight.
- start pulsed mid-frame ignored; abort at pixel 1000 → busy=0 within 2 cycles, no done, fresh start completes full frame.
- Assert reset mid-frame → all outputs 0 same cycle; post-reset start runs normally.
